// File: rtl/velocity_update_sequencer_pkg.sv
// Shared types and constants for the per-cell velocity read-modify-write sequencer.
// Payload words are {vz, vy, vx} single-precision floats.
package velocity_update_sequencer_pkg;

  localparam int VUS_DATA_WIDTH = 96;

  localparam int VX_LSB = 0;
  localparam int VX_MSB = 31;
  localparam int VY_LSB = 32;
  localparam int VY_MSB = 63;
  localparam int VZ_LSB = 64;
  localparam int VZ_MSB = 95;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RD_CNT   = 4'd1,
    S_WAIT_CNT = 4'd2,
    S_RD_P     = 4'd3,
    S_WAIT_P   = 4'd4,
    S_ISSUE    = 4'd5,
    S_WAIT_RES = 4'd6,
    S_WR       = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  function automatic logic is_rd_state(input state_t s);
    return (s == S_RD_CNT) || (s == S_RD_P);
  endfunction

  function automatic logic is_wait_state(input state_t s);
    return (s == S_WAIT_CNT) || (s == S_WAIT_P);
  endfunction

endpackage

// File: rtl/velocity_update_sequencer_if.sv
// Memory, force-cache and motion-update-unit signals of one cell sequencer.
// master = sequencer side, slave = memories plus update unit.
interface velocity_update_sequencer_if
  import velocity_update_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = VUS_DATA_WIDTH,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [ADDR_WIDTH-1:0] force_address;
  logic                  force_rden;
  logic [DATA_WIDTH-1:0] force_q;
  logic                  upd_valid;
  logic                  upd_ready;
  logic [DATA_WIDTH-1:0] upd_vel;
  logic [DATA_WIDTH-1:0] upd_force;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_vel;

  modport master (
    output mem_address, mem_rden, mem_wren, mem_data,
    input  mem_q,
    output force_address, force_rden,
    input  force_q,
    output upd_valid, upd_vel, upd_force,
    input  upd_ready,
    input  res_valid, res_vel
  );

  modport slave (
    input  mem_address, mem_rden, mem_wren, mem_data,
    output mem_q,
    input  force_address, force_rden,
    output force_q,
    input  upd_valid, upd_vel, upd_force,
    output upd_ready,
    output res_valid, res_vel
  );
endinterface

// File: rtl/velocity_update_sequencer_rd_latency_counter.sv
// Down-counter armed during a read cycle; expire_o pulses in the wait cycle
// where the memory read data becomes valid.
module velocity_update_sequencer_rd_latency_counter #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(RD_LATENCY);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CW'(1));
endmodule

// File: rtl/velocity_update_sequencer.sv
// Walks particles 1..N of one cell: read velocity and force, hand them to the
// motion-update unit, write the returned velocity back to the same address.
module velocity_update_sequencer
  import velocity_update_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = VUS_DATA_WIDTH,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int RD_LATENCY   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  velocity_update_sequencer_if.master bus,
  output logic [ADDR_WIDTH-1:0]      particle_count,
  output logic                       busy,
  output logic                       done,
  output logic                       count_err
);
  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic                  mem_rden_q;
  logic                  mem_wren_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic [ADDR_WIDTH-1:0] force_address_q;
  logic                  force_rden_q;
  logic                  upd_valid_q;
  logic [DATA_WIDTH-1:0] upd_vel_q;
  logic [DATA_WIDTH-1:0] upd_force_q;
  logic [ADDR_WIDTH-1:0] particle_count_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  count_err_q;

  logic                  lat_expire;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic                  cnt_over;
  logic [ADDR_WIDTH-1:0] cnt_d;

  velocity_update_sequencer_rd_latency_counter #(
    .RD_LATENCY (RD_LATENCY)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load_i   (is_rd_state(state_q)),
    .en_i     (is_wait_state(state_q)),
    .expire_o (lat_expire)
  );

  // A corrupt count word must never walk the sequencer past the memory depth.
  assign cnt_raw  = bus.mem_q[ADDR_WIDTH-1:0];
  assign cnt_over = cnt_raw > MAX_IDX;
  assign cnt_d    = cnt_over ? MAX_IDX : cnt_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      cnt_q            <= '0;
      mem_address_q    <= '0;
      mem_rden_q       <= 1'b0;
      mem_wren_q       <= 1'b0;
      mem_data_q       <= '0;
      force_address_q  <= '0;
      force_rden_q     <= 1'b0;
      upd_valid_q      <= 1'b0;
      upd_vel_q        <= '0;
      upd_force_q      <= '0;
      particle_count_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      count_err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q        <= 1'b1;
            mem_rden_q    <= 1'b1;
            mem_address_q <= '0;
            state_q       <= S_RD_CNT;
          end
        end
        S_RD_CNT: begin
          mem_rden_q <= 1'b0;
          state_q    <= S_WAIT_CNT;
        end
        S_WAIT_CNT: begin
          if (lat_expire) begin
            cnt_q            <= cnt_d;
            particle_count_q <= cnt_d;
            if (cnt_over) begin
              count_err_q <= 1'b1;
            end
            if (cnt_d == '0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              idx_q           <= ADDR_WIDTH'(1);
              mem_rden_q      <= 1'b1;
              force_rden_q    <= 1'b1;
              mem_address_q   <= ADDR_WIDTH'(1);
              force_address_q <= ADDR_WIDTH'(1);
              state_q         <= S_RD_P;
            end
          end
        end
        S_RD_P: begin
          mem_rden_q      <= 1'b0;
          force_rden_q    <= 1'b0;
          mem_address_q   <= '0;
          force_address_q <= '0;
          state_q         <= S_WAIT_P;
        end
        S_WAIT_P: begin
          if (lat_expire) begin
            upd_vel_q   <= bus.mem_q;
            upd_force_q <= bus.force_q;
            upd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // upd_vel/upd_force stay untouched until the next particle is read.
          if (bus.upd_ready) begin
            upd_valid_q <= 1'b0;
            state_q     <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (bus.res_valid) begin
            mem_data_q    <= bus.res_vel;
            mem_wren_q    <= 1'b1;
            mem_address_q <= idx_q;
            state_q       <= S_WR;
          end
        end
        S_WR: begin
          mem_wren_q    <= 1'b0;
          mem_data_q    <= '0;
          mem_address_q <= '0;
          if (idx_q == cnt_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            idx_q           <= idx_q + ADDR_WIDTH'(1);
            mem_rden_q      <= 1'b1;
            force_rden_q    <= 1'b1;
            mem_address_q   <= idx_q + ADDR_WIDTH'(1);
            force_address_q <= idx_q + ADDR_WIDTH'(1);
            state_q         <= S_RD_P;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_address   = mem_address_q;
  assign bus.mem_rden      = mem_rden_q;
  assign bus.mem_wren      = mem_wren_q;
  assign bus.mem_data      = mem_data_q;
  assign bus.force_address = force_address_q;
  assign bus.force_rden    = force_rden_q;
  assign bus.upd_valid     = upd_valid_q;
  assign bus.upd_vel       = upd_vel_q;
  assign bus.upd_force     = upd_force_q;
  assign particle_count    = particle_count_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign count_err         = count_err_q;
endmodule

// File: tb/tb_velocity_update_sequencer.sv
// Directed bench: behavioural velocity/force memories, a scripted update unit,
// and hand-computed expectations for each pass.
module tb_velocity_update_sequencer;
  import velocity_update_sequencer_pkg::*;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] particle_count;
  logic          busy;
  logic          done;
  logic          count_err;

  velocity_update_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  velocity_update_sequencer #(
    .DATA_WIDTH   (DW),
    .PARTICLE_NUM (PN),
    .ADDR_WIDTH   (AW),
    .RD_LATENCY   (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .bus            (bus),
    .particle_count (particle_count),
    .busy           (busy),
    .done           (done),
    .count_err      (count_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] vel_pat(input int a, input int s);
    logic [95:0] v;
    v = '0;
    v[VX_MSB:VX_LSB] = 32'h3F80_0000 + 32'(a * 3);
    v[VY_MSB:VY_LSB] = 32'h4000_0000 | 32'(a);
    v[VZ_MSB:VZ_LSB] = 32'hC000_0000 | 32'(s << 8) | 32'(a);
    return v;
  endfunction

  function automatic logic [95:0] force_pat(input int a);
    return {32'hBF00_0000 + 32'(a), 32'h0000_1000 + 32'(a), 32'hDEAD_0000 + 32'(a)};
  endfunction

  // Velocity memory (preloadable) and force cache, both one-cycle registered reads
  logic [DW-1:0] vel_mem [0:PN-1];
  logic          preload_req = 1'b0;
  int            seed_cfg = 0;
  int            count_cfg = 0;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < PN; i++) vel_mem[i] <= vel_pat(i, seed_cfg);
      vel_mem[0] <= 96'(count_cfg);
    end else if (bus.mem_wren) begin
      vel_mem[bus.mem_address] <= bus.mem_data;
    end
    if (bus.mem_rden) bus.mem_q <= vel_mem[bus.mem_address];
    if (bus.force_rden) bus.force_q <= force_pat(int'(bus.force_address));
  end

  // Bus monitor
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int done_cnt = 0, busy_gap = 0, rw_viol = 0, addr_viol = 0, rd0_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem_wren) begin
      wr_addr.push_back(bus.mem_address);
      wr_data.push_back(bus.mem_data);
      if (!busy) busy_gap++;
    end
    if (bus.mem_rden && bus.mem_wren) rw_viol++;
    if (!bus.mem_rden && !bus.mem_wren && bus.mem_address != '0) addr_viol++;
    if (!bus.force_rden && bus.force_address != '0) addr_viol++;
    if (done) done_cnt++;
    if (bus.mem_rden && bus.mem_address == '0) rd0_cnt++;
  end

  // Scripted update unit: optional stall, result = vel ^ 1 after res_delay_cfg cycles
  int stall_cfg = 0;
  int res_delay_cfg = 2;
  bit spur_en = 1'b0;
  int acc_cnt = 0, stall_seen = 0, drop_viol = 0, stab_viol = 0;
  logic [DW-1:0] acc_vel [$];
  logic [DW-1:0] acc_force [$];

  initial begin
    bit            pend, prev_valid, prev_ready, rdy;
    int            pend_left, stall_left;
    logic [DW-1:0] pend_vel, prev_vel, prev_force;
    pend = 0; prev_valid = 0; prev_ready = 0; pend_left = 0; stall_left = 0;
    pend_vel = '0; prev_vel = '0; prev_force = '0;
    bus.upd_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_vel   = '0;
    forever begin
      @(negedge clk);
      bus.res_valid = 1'b0;
      if (rst) begin
        pend = 0; prev_valid = 0; prev_ready = 0;
        bus.upd_ready = 1'b0;
        continue;
      end
      if (prev_valid && !prev_ready) begin
        if (!bus.upd_valid) drop_viol++;
        else if (bus.upd_vel !== prev_vel || bus.upd_force !== prev_force) stab_viol++;
      end
      if (pend) begin
        pend_left--;
        if (pend_left == 0) begin
          pend = 0;
          bus.res_valid = 1'b1;
          bus.res_vel   = pend_vel;
        end
      end
      rdy = 1'b0;
      if (bus.upd_valid) begin
        if (!prev_valid) begin
          stall_left = stall_cfg;
          if (spur_en && stall_left > 0) begin
            bus.res_valid = 1'b1;
            bus.res_vel   = '1;
          end
        end
        if (stall_left > 0) begin
          stall_left--;
          stall_seen++;
        end else begin
          rdy = 1'b1;
          acc_cnt++;
          acc_vel.push_back(bus.upd_vel);
          acc_force.push_back(bus.upd_force);
          pend      = 1;
          pend_left = res_delay_cfg;
          pend_vel  = bus.upd_vel ^ 96'h1;
        end
      end
      bus.upd_ready = rdy;
      prev_valid = bus.upd_valid;
      prev_ready = rdy;
      prev_vel   = bus.upd_vel;
      prev_force = bus.upd_force;
    end
  end

  task automatic preload(input int cnt, input int seed);
    count_cfg = cnt;
    seed_cfg  = seed;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_done_seen"}, done, 1);
  endtask

  task automatic check_writes(input string tag, input int base, input int n, input int seed);
    chk({tag, "_nwr"}, wr_addr.size() - base, n);
    for (int i = 0; i < n && base + i < wr_addr.size(); i++) begin
      chk({tag, "_wr_addr"}, wr_addr[base + i], i + 1);
      chk({tag, "_wr_data"}, wr_data[base + i], vel_pat(i + 1, seed) ^ 96'h1);
    end
  endtask

  initial begin
    int cyc, wb, ab, db, sb, rb;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {bus.mem_rden, bus.mem_wren, bus.mem_address, bus.force_rden,
                        bus.force_address, bus.upd_valid, busy, done, count_err, particle_count}, 0);
    chk("rst_mem_data", bus.mem_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: three particles, immediate ready, result two cycles after accept
    preload(3, 1);
    wb = wr_addr.size(); ab = acc_cnt; db = done_cnt;
    pulse_start();
    chk("T1_busy_start", busy, 1);
    wait_done("T1", 200, cyc);
    @(negedge clk);
    chk("T1_busy_end", busy, 0);
    check_writes("T1", wb, 3, 1);
    chk("T1_done_pulses", done_cnt - db, 1);
    chk("T1_pcount", particle_count, 3);
    chk("T1_accepts", acc_cnt - ab, 3);
    for (int i = 0; i < 3 && ab + i < acc_vel.size(); i++) begin
      chk("T1_upd_vel", acc_vel[ab + i], vel_pat(i + 1, 1));
      chk("T1_upd_force", acc_force[ab + i], force_pat(i + 1));
    end
    chk("T1_busy_gap", busy_gap, 0);
    $display("pass T1: count=3 writes=%0d", wr_addr.size() - wb);

    // T2: empty cell
    preload(0, 2);
    wb = wr_addr.size(); ab = acc_cnt; db = done_cnt;
    pulse_start();
    wait_done("T2", 50, cyc);
    chk("T2_done_latency", cyc + 1, 3);
    @(negedge clk);
    chk("T2_nwr", wr_addr.size() - wb, 0);
    chk("T2_accepts", acc_cnt - ab, 0);
    chk("T2_done_pulses", done_cnt - db, 1);
    chk("T2_pcount", particle_count, 0);
    chk("T2_count_err", count_err, 0);
    $display("pass T2: count=0 writes=%0d", wr_addr.size() - wb);

    // T3: count word beyond memory depth is clamped
    res_delay_cfg = 1;
    preload(250, 3);
    wb = wr_addr.size();
    pulse_start();
    wait_done("T3", 3000, cyc);
    @(negedge clk);
    chk("T3_count_err", count_err, 1);
    chk("T3_pcount", particle_count, 219);
    chk("T3_last_addr", wr_addr[$], 219);
    check_writes("T3", wb, 219, 3);
    $display("pass T3: count=250 writes=%0d", wr_addr.size() - wb);

    // T4: update unit stalls ten cycles
    res_delay_cfg = 2;
    stall_cfg = 10;
    preload(1, 4);
    wb = wr_addr.size(); ab = acc_cnt; sb = stall_seen;
    pulse_start();
    wait_done("T4", 200, cyc);
    @(negedge clk);
    stall_cfg = 0;
    chk("T4_stall_cycles", stall_seen - sb, 10);
    chk("T4_accepts", acc_cnt - ab, 1);
    chk("T4_drop_viol", drop_viol, 0);
    chk("T4_stab_viol", stab_viol, 0);
    chk("T4_err_sticky", count_err, 1);
    check_writes("T4", wb, 1, 4);
    $display("pass T4: count=1 writes=%0d", wr_addr.size() - wb);

    // T5: spurious result during ISSUE and a start while busy
    stall_cfg = 3;
    spur_en = 1'b1;
    preload(2, 5);
    wb = wr_addr.size(); db = done_cnt;
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    wait_done("T5", 200, cyc);
    repeat (15) @(negedge clk);
    stall_cfg = 0;
    spur_en = 1'b0;
    chk("T5_done_pulses", done_cnt - db, 1);
    chk("T5_busy_after", busy, 0);
    chk("T5_stab_viol", stab_viol, 0);
    check_writes("T5", wb, 2, 5);
    $display("pass T5: count=2 writes=%0d", wr_addr.size() - wb);

    // T6: reset while waiting for particle 2's result, then rerun
    res_delay_cfg = 20;
    preload(3, 6);
    wb = wr_addr.size(); ab = acc_cnt;
    pulse_start();
    cyc = 0;
    while (acc_cnt - ab < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("T6_second_accept", acc_cnt - ab, 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("T6_rst_outputs", {bus.mem_rden, bus.mem_wren, bus.mem_address, bus.force_rden,
                           bus.force_address, bus.upd_valid, busy, done, count_err, particle_count}, 0);
    chk("T6_rst_upd_vel", bus.upd_vel, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("T6_abort_nwr", wr_addr.size() - wb, 1);
    chk("T6_abort_addr", wr_addr[$], 1);
    res_delay_cfg = 2;
    preload(3, 7);
    wb = wr_addr.size(); rb = rd0_cnt;
    pulse_start();
    wait_done("T6", 200, cyc);
    @(negedge clk);
    chk("T6_rd_count_word", rd0_cnt - rb, 1);
    chk("T6_pcount", particle_count, 3);
    check_writes("T6", wb, 3, 7);
    $display("pass T6: rerun count=3 writes=%0d", wr_addr.size() - wb);

    chk("mem_rw_overlap", rw_viol, 0);
    chk("addr_when_idle", addr_viol, 0);
    chk("drop_viol_final", drop_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/velocity_update_sequencer.md
Name: velocity_update_sequencer

Overview:
Per-cell read-modify-write sequencer that sits directly upstream of a cell's velocity memory (single-port, address 0 = particle count, payload {vz, vy, vx}).
After a force-evaluation pass, it walks particles 1..N of one cell:
- reads the current velocity and the matching accumulated force;
- hands both to the external FP motion-update unit over a valid/ready handshake;
- writes the returned velocity back to the same address.
One instance per cell; the motion-update controller starts every cell and waits for done.

Parameters:
DATA_WIDTH, 96, velocity/force word width, {z,y,x} single-precision floats
PARTICLE_NUM, 220, depth of the cell velocity memory (words, including count word)
ADDR_WIDTH, 8, memory address width
RD_LATENCY, 1, cycles from rden asserted to valid mem_q/force_q

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begin a pass (ignored unless IDLE)
mem_address  out  ADDR_WIDTH  velocity memory address
mem_rden  out  1  velocity memory read enable
mem_wren  out  1  velocity memory write enable
mem_data  out  DATA_WIDTH  write data to velocity memory
mem_q  in  DATA_WIDTH  read data from velocity memory
force_address  out  ADDR_WIDTH  force cache read address (same index as mem_address)
force_rden  out  1  force cache read enable
force_q  in  DATA_WIDTH  accumulated force {Fz,Fy,Fx}
upd_valid  out  1  velocity/force pair presented to update unit
upd_ready  in  1  update unit accepts pair
upd_vel  out  DATA_WIDTH  current velocity to update unit
upd_force  out  DATA_WIDTH  force to update unit
res_valid  in  1  updated velocity returned (single-cycle strobe)
res_vel  in  DATA_WIDTH  updated velocity
particle_count  out  ADDR_WIDTH  count read from address 0 this pass
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of pass
count_err  out  1  sticky: stored count exceeded PARTICLE_NUM-1

Behaviour:
- Reset: all outputs 0, FSM = IDLE, internal index = 0. count_err is cleared only by rst. rst mid-pass aborts immediately; no further write is issued.
- FSM states and transitions:
  - IDLE: on start go to RD_CNT.
  - RD_CNT: mem_address=0, mem_rden=1 for one cycle, then WAIT_CNT.
  - WAIT_CNT: wait RD_LATENCY cycles, then latch cnt = mem_q[ADDR_WIDTH-1:0].
    - If cnt > PARTICLE_NUM-1: clamp to PARTICLE_NUM-1 and set count_err.
    - If cnt == 0: go to DONE.
    - Otherwise set idx = 1 and go to RD_P.
  - RD_P: mem_address = force_address = idx, mem_rden = force_rden = 1 for one cycle, then WAIT_P.
  - WAIT_P: wait RD_LATENCY cycles, capture mem_q into upd_vel and force_q into upd_force, then ISSUE.
  - ISSUE: upd_valid=1, with upd_vel/upd_force held stable until the cycle where upd_valid & upd_ready; then WAIT_RES.
  - WAIT_RES: wait indefinitely for res_valid; capture res_vel into mem_data; then WR.
  - WR: mem_address=idx, mem_wren=1, mem_rden=0 for exactly one cycle.
    - If idx == cnt go to DONE; else idx++ and go to RD_P.
  - DONE: done=1 for one cycle, busy falls, return to IDLE.
- Handshake rules: upd_valid is never dropped before acceptance. res_valid outside WAIT_RES is ignored. The block holds at most one outstanding particle, so it is strictly in-order.
- Memory rules: mem_rden and mem_wren are never both high. mem_address and force_address are zero whenever the matching enable is low.
- start while busy: ignored.
- Latency per particle (ready and result immediate): 1 + RD_LATENCY + 1 + 1 + 1 cycles. Pass latency is 2 + RD_LATENCY + N×(4 + RD_LATENCY) + 1 cycles.
- Data is passed bit-exact; the block does no arithmetic on payloads.

Decomposition:
- Shared package/defines:
  - FSM state encoding (localparam enum, 4 bits);
  - DATA_WIDTH default 96;
  - field slices VX=[31:0], VY=[63:32], VZ=[95:64].
- Sub-module: rd_latency_counter, a small down-counter reused by WAIT_CNT and WAIT_P that pulses when RD_LATENCY expires.
- All else stays in one module.

Test Plan:
- Count=3, RD_LATENCY=1, upd_ready=1, res returned 2 cycles after accept with res_vel = upd_vel ^ 96'h1 -> writes at addresses 1, 2, 3 with flipped LSB; a single done pulse; busy spans the whole pass; particle_count=3.
- Count=0 -> no upd_valid and no mem_wren; done 1 cycle after the count is latched.
- Count=250 with PARTICLE_NUM=220 -> count_err=1, particle_count=219, last write at address 219.
- upd_ready held low 10 cycles -> upd_valid, upd_vel and upd_force stable all 10 cycles; exactly one accept.
- Spurious res_valid in ISSUE and start pulse while busy -> both ignored; write data still equals the in-order result.
- rst asserted during WAIT_RES of particle 2 -> all outputs 0 next cycle, no write to address 2; a following start reruns from address 0.
